bp_me_cache_to_cce: RTL

- Initiator-side bridge: accepts bsg_cache packets from a cache-packet client (accelerator, test driver, or the tag-init/flush engine).
- Issues BP CCE uncached memory commands (header + dword data) toward a CCE-mem responder.
- Returns load data to the client in bsg_cache response format, in order.
- Sits on the client side of a mem_cmd/mem_resp link whose far end is the existing cache-side adapter.

---
 rtl/bp_me_pkg.sv | 112 +++++++++++
 rtl/bp_me_cache_to_cce_load_align.sv | 32 +++
 rtl/bp_me_cache_to_cce.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/bp_me_pkg.sv
// Shared types for the cache-packet to CCE uncached bridge: bsg_cache packet,
// CCE mem header, pending entry and the bsg_cache opcode decode.
package bp_me_pkg;

  localparam int unsigned paddr_width_p         = 40;
  localparam int unsigned dword_width_p         = 64;
  localparam int unsigned lce_id_width_p        = 4;
  localparam int unsigned lce_assoc_p           = 8;
  localparam int unsigned lce_sets_p            = 64;
  localparam int unsigned cce_block_width_p     = 512;
  localparam int unsigned block_offset_width_lp = $clog2(cce_block_width_p / 8);
  localparam int unsigned lg_sets_lp            = $clog2(lce_sets_p);
  localparam int unsigned lg_ways_lp            = $clog2(lce_assoc_p);

  localparam logic [paddr_width_p-1:0] cache_tagfl_base_addr_gp = 40'h00_0020_0000;

  typedef enum logic [5:0] {
    e_cache_lb    = 6'h00,
    e_cache_lh    = 6'h01,
    e_cache_lw    = 6'h02,
    e_cache_ld    = 6'h03,
    e_cache_lbu   = 6'h04,
    e_cache_lhu   = 6'h05,
    e_cache_lwu   = 6'h06,
    e_cache_tagst = 6'h08,
    e_cache_tagfl = 6'h09,
    e_cache_sb    = 6'h10,
    e_cache_sh    = 6'h11,
    e_cache_sw    = 6'h12,
    e_cache_sd    = 6'h13
  } bsg_cache_opcode_e;

  typedef struct packed {
    bsg_cache_opcode_e            opcode;
    logic [paddr_width_p-1:0]     addr;
    logic [dword_width_p-1:0]     data;
    logic [dword_width_p/8-1:0]   mask;
  } bsg_cache_pkt_s;

  localparam int unsigned bsg_cache_pkt_width_lp = $bits(bsg_cache_pkt_s);

  typedef enum logic [3:0] {
    e_mem_msg_rd    = 4'd0,
    e_mem_msg_wr    = 4'd1,
    e_mem_msg_uc_rd = 4'd2,
    e_mem_msg_uc_wr = 4'd3
  } bp_mem_msg_e;

  typedef enum logic [2:0] {
    e_mem_msg_size_1  = 3'd0,
    e_mem_msg_size_2  = 3'd1,
    e_mem_msg_size_4  = 3'd2,
    e_mem_msg_size_8  = 3'd3,
    e_mem_msg_size_16 = 3'd4,
    e_mem_msg_size_32 = 3'd5,
    e_mem_msg_size_64 = 3'd6
  } bp_mem_msg_size_e;

  typedef struct packed {
    logic [lce_id_width_p-1:0] lce_id;
    logic [lg_ways_lp-1:0]     way_id;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    bp_cce_mem_payload_s       payload;
    bp_mem_msg_size_e          size;
    logic [paddr_width_p-1:0]  addr;
    bp_mem_msg_e               msg_type;
  } bp_cce_mem_msg_header_s;

  localparam int unsigned cce_mem_msg_header_width = $bits(bp_cce_mem_msg_header_s);

  typedef struct packed {
    bsg_cache_opcode_e opcode;
    logic [2:0]        byte_offset;
  } bp_me_cache_pending_s;

  typedef struct packed {
    bp_mem_msg_e      msg_type;
    bp_mem_msg_size_e size;
    logic             is_load;
    logic             is_signed;
    logic             supported;
  } bp_me_cache_decode_s;

  // Opcode to CCE message attributes; unsupported opcodes report supported=0
  function automatic bp_me_cache_decode_s bp_me_cache_decode(input bsg_cache_opcode_e op);
    bp_me_cache_decode_s dec;
    dec.msg_type  = e_mem_msg_uc_wr;
    dec.size      = e_mem_msg_size_8;
    dec.is_load   = 1'b0;
    dec.is_signed = 1'b0;
    dec.supported = 1'b1;
    case (op)
      e_cache_lb:    begin dec.msg_type = e_mem_msg_uc_rd; dec.size = e_mem_msg_size_1; dec.is_load = 1'b1; dec.is_signed = 1'b1; end
      e_cache_lh:    begin dec.msg_type = e_mem_msg_uc_rd; dec.size = e_mem_msg_size_2; dec.is_load = 1'b1; dec.is_signed = 1'b1; end
      e_cache_lw:    begin dec.msg_type = e_mem_msg_uc_rd; dec.size = e_mem_msg_size_4; dec.is_load = 1'b1; dec.is_signed = 1'b1; end
      e_cache_ld:    begin dec.msg_type = e_mem_msg_uc_rd; dec.size = e_mem_msg_size_8; dec.is_load = 1'b1; end
      e_cache_lbu:   begin dec.msg_type = e_mem_msg_uc_rd; dec.size = e_mem_msg_size_1; dec.is_load = 1'b1; end
      e_cache_lhu:   begin dec.msg_type = e_mem_msg_uc_rd; dec.size = e_mem_msg_size_2; dec.is_load = 1'b1; end
      e_cache_lwu:   begin dec.msg_type = e_mem_msg_uc_rd; dec.size = e_mem_msg_size_4; dec.is_load = 1'b1; end
      e_cache_sb:    dec.size = e_mem_msg_size_1;
      e_cache_sh:    dec.size = e_mem_msg_size_2;
      e_cache_sw:    dec.size = e_mem_msg_size_4;
      e_cache_sd:    dec.size = e_mem_msg_size_8;
      e_cache_tagfl: dec.size = e_mem_msg_size_8;
      default:       dec.supported = 1'b0;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/bp_me_cache_to_cce_load_align.sv
// Aligns a returned dword to the load's byte offset and sign/zero-extends it
// to the access size; non-load responses yield zero.
module bp_me_cache_to_cce_load_align
  import bp_me_pkg::*;
  (
    input  logic [dword_width_p-1:0] data_i,
    input  logic [2:0]               offset_i,
    input  logic [2:0]               size_i,
    input  logic                     is_load_i,
    input  logic                     is_signed_i,
    output logic [dword_width_p-1:0] data_o
  );

  logic [dword_width_p-1:0] shifted;
  assign shifted = data_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = '0;
    if (is_load_i) begin
      case (bp_mem_msg_size_e'(size_i))
        e_mem_msg_size_1: data_o = is_signed_i ? {{(dword_width_p-8){shifted[7]}}, shifted[7:0]}
                                               : dword_width_p'(shifted[7:0]);
        e_mem_msg_size_2: data_o = is_signed_i ? {{(dword_width_p-16){shifted[15]}}, shifted[15:0]}
                                               : dword_width_p'(shifted[15:0]);
        e_mem_msg_size_4: data_o = is_signed_i ? {{(dword_width_p-32){shifted[31]}}, shifted[31:0]}
                                               : dword_width_p'(shifted[31:0]);
        default:          data_o = shifted;
      endcase
    end
  end

endmodule

// File: rtl/bp_me_cache_to_cce.sv
// bsg_cache packet client to BP CCE uncached mem_cmd/mem_resp bridge, in-order.
// Optional BP_ME_CACHE_TO_CCE_RESP_REG_EN adds a 2-entry registered response buffer.
module bp_me_cache_to_cce
  import bp_me_pkg::*;
  #(
    parameter int unsigned outstanding_p = 4,
    parameter int unsigned lce_id_p      = 0
  )
  (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [bsg_cache_pkt_width_lp-1:0]   cache_pkt_i,
    input  logic                                cache_pkt_v_i,
    output logic                                cache_pkt_ready_o,
    output logic [dword_width_p-1:0]            cache_data_o,
    output logic                                cache_v_o,
    input  logic                                cache_yumi_i,
    output logic [cce_mem_msg_header_width-1:0] mem_cmd_header_o,
    output logic [dword_width_p-1:0]            mem_cmd_data_o,
    output logic                                mem_cmd_v_o,
    input  logic                                mem_cmd_ready_i,
    input  logic [cce_mem_msg_header_width-1:0] mem_resp_header_i,
    input  logic [dword_width_p-1:0]            mem_resp_data_i,
    input  logic                                mem_resp_v_i,
    output logic                                mem_resp_yumi_o,
    output logic                                error_o
  );

  localparam int unsigned ptr_w_lp = $clog2(outstanding_p);
  localparam int unsigned cnt_w_lp = $clog2(outstanding_p + 1);
  localparam logic [cnt_w_lp-1:0] max_credits_lp = cnt_w_lp'(outstanding_p);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp    = ptr_w_lp'(outstanding_p - 1);

  typedef enum logic {e_reset, e_ready} state_e;
  state_e state_q, state_d;

  bsg_cache_pkt_s         pkt;
  bp_me_cache_decode_s    pkt_dec, head_dec;
  bp_cce_mem_msg_header_s cmd_header, resp_header;
  bp_me_cache_pending_s   fifo_head;
  bp_me_cache_pending_s   fifo_mem_q [outstanding_p];

  logic [ptr_w_lp-1:0]      wptr_q, rptr_q, wptr_next, rptr_next;
  logic [cnt_w_lp-1:0]      fifo_cnt_q, credits_q;
  logic                     error_q;
  logic                     fifo_empty, credit_avail;
  logic                     pkt_ready, cmd_v, resp_yumi, cache_v;
  logic                     issue, resp_consume, drop, mismatch, unsupported_ack, credit_ret;
  logic [dword_width_p-1:0] cmd_data, aligned_data;

  assign pkt         = bsg_cache_pkt_s'(cache_pkt_i);
  assign pkt_dec     = bp_me_cache_decode(pkt.opcode);
  assign resp_header = bp_cce_mem_msg_header_s'(mem_resp_header_i);
  assign fifo_head   = fifo_mem_q[rptr_q];
  assign head_dec    = bp_me_cache_decode(fifo_head.opcode);

  assign fifo_empty   = (fifo_cnt_q == '0);
  assign credit_avail = (credits_q < max_credits_lp);
  assign wptr_next    = (wptr_q == last_ptr_lp) ? '0 : wptr_q + 1'b1;
  assign rptr_next    = (rptr_q == last_ptr_lp) ? '0 : rptr_q + 1'b1;

`ifdef BP_ME_CACHE_TO_CCE_RESP_REG_EN
  logic [dword_width_p-1:0] buf_q [2];
  logic                     buf_head_q;
  logic [1:0]               buf_cnt_q;
  logic                     buf_full, buf_empty, buf_pop;

  assign buf_full  = (buf_cnt_q == 2'd2);
  assign buf_empty = (buf_cnt_q == 2'd0);
  assign buf_pop   = cache_v & cache_yumi_i;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= e_reset;
    else            state_q <= state_d;
  end

  // Next state and handshake outputs; reset forces every valid/ready low
  always_comb begin
    state_d   = state_q;
    pkt_ready = 1'b0;
    cmd_v     = 1'b0;
    resp_yumi = 1'b0;
    cache_v   = 1'b0;
    case (state_q)
      e_reset: state_d = e_ready;
      e_ready: begin
        if (pkt_dec.supported) begin
          cmd_v     = cache_pkt_v_i & credit_avail;
          pkt_ready = mem_cmd_ready_i & credit_avail;
        end else begin
          pkt_ready = 1'b1;
        end
`ifdef BP_ME_CACHE_TO_CCE_RESP_REG_EN
        resp_yumi = mem_resp_v_i & (fifo_empty | ~buf_full);
        cache_v   = ~buf_empty;
`else
        cache_v   = mem_resp_v_i & ~fifo_empty;
        resp_yumi = mem_resp_v_i & (fifo_empty | cache_yumi_i);
`endif
      end
      default: state_d = e_reset;
    endcase
    if (!reset_n_i) begin
      state_d   = e_reset;
      pkt_ready = 1'b0;
      cmd_v     = 1'b0;
      resp_yumi = 1'b0;
      cache_v   = 1'b0;
    end
  end

  assign issue           = cmd_v & mem_cmd_ready_i;
  assign unsupported_ack = cache_pkt_v_i & pkt_ready & ~pkt_dec.supported;
  assign resp_consume    = resp_yumi & ~fifo_empty;
  assign drop            = resp_yumi & fifo_empty;
  assign mismatch        = resp_consume & (resp_header.msg_type != head_dec.msg_type);

  // Command header and lane-replicated store data
  always_comb begin
    cmd_header                = '0;
    cmd_header.payload.lce_id = lce_id_width_p'(lce_id_p);
    cmd_header.msg_type       = pkt_dec.msg_type;
    cmd_header.size           = pkt_dec.size;
    cmd_header.addr           = pkt.addr;
    cmd_data                  = pkt.data;
    case (pkt_dec.size)
      e_mem_msg_size_1: cmd_data = {(dword_width_p/8){pkt.data[7:0]}};
      e_mem_msg_size_2: cmd_data = {(dword_width_p/16){pkt.data[15:0]}};
      e_mem_msg_size_4: cmd_data = {(dword_width_p/32){pkt.data[31:0]}};
      default:          cmd_data = pkt.data;
    endcase
    if (pkt.opcode == e_cache_tagfl) begin
      cmd_header.addr = cache_tagfl_base_addr_gp;
      cmd_data        = dword_width_p'(pkt.addr[block_offset_width_lp +: (lg_sets_lp + lg_ways_lp)]);
    end
  end

  bp_me_cache_to_cce_load_align u_align (
    .data_i      (mem_resp_data_i),
    .offset_i    (fifo_head.byte_offset),
    .size_i      (head_dec.size),
    .is_load_i   (head_dec.is_load),
    .is_signed_i (head_dec.is_signed),
    .data_o      (aligned_data)
  );

`ifdef BP_ME_CACHE_TO_CCE_RESP_REG_EN
  assign credit_ret   = buf_pop;
  assign cache_data_o = buf_q[buf_head_q];

  // Two-entry response buffer; push and pop may coincide for full throughput
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      buf_head_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
    end else begin
      if (buf_pop) buf_head_q <= ~buf_head_q;
      buf_cnt_q <= buf_cnt_q + 2'(resp_consume) - 2'(buf_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (resp_consume) buf_q[buf_head_q ^ buf_cnt_q[0]] <= aligned_data;
  end
`else
  assign credit_ret   = resp_consume;
  assign cache_data_o = aligned_data;
`endif

  // Pending-queue pointers, credit counter and sticky error
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_cnt_q <= '0;
      credits_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      if (issue)        wptr_q <= wptr_next;
      if (resp_consume) rptr_q <= rptr_next;
      fifo_cnt_q <= fifo_cnt_q + cnt_w_lp'(issue) - cnt_w_lp'(resp_consume);
      credits_q  <= credits_q + cnt_w_lp'(issue) - cnt_w_lp'(credit_ret);
      if (drop | mismatch | unsupported_ack) error_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue) begin
      fifo_mem_q[wptr_q].opcode      <= pkt.opcode;
      fifo_mem_q[wptr_q].byte_offset <= pkt.addr[2:0];
    end
  end

  assign cache_pkt_ready_o = pkt_ready;
  assign mem_cmd_v_o       = cmd_v;
  assign mem_cmd_header_o  = cmd_header;
  assign mem_cmd_data_o    = cmd_data;
  assign cache_v_o         = cache_v;
  assign mem_resp_yumi_o   = resp_yumi;
  assign error_o           = error_q;

  logic unused_bits;
  assign unused_bits = ^{pkt.mask, resp_header.addr, resp_header.size, resp_header.payload,
                         pkt_dec.is_load, pkt_dec.is_signed, head_dec.supported};

endmodule
